imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Owns the single port of the instruction BRAM and shares it between three requesters:
//  - program loader: writes, boot only
//  - instruction fetch: reads
//  - debug reader: reads
//  Sequences boot (load) versus run mode and gates the core through core_run.
//  Returns read data tagged to the requester that issued the read.
//  Sits between the fetch stage / loader / debug unit and the instruction memory macro.
// PARAMETERS
//  ADDR_W      16  word-address width of the instruction memory
//  DATA_W      32  instruction word width
//  RD_LAT      1   BRAM read latency in cycles (legal 1..3)
//  STARVE_MAX  15  blocked-cycle count after which debug overrides fetch
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst        in   1       asynchronous, active-high reset
//  ld_start   in   1       pulse: request (re)entry into boot mode
//  ld_req     in   1       loader write request, held until ld_ack
//  ld_addr    in   ADDR_W  loader write address
//  ld_data    in   DATA_W  loader write data
//  ld_ack     out  1       one-cycle pulse: write issued this cycle
//  ld_done    in   1       pulse: image complete, enter run mode
//  core_run   out  1       high only in RUN; gates the core's stage enables
//  f_req      in   1       fetch read request (single cycle)
//  f_addr     in   ADDR_W  fetch address
//  f_gnt      out  1       fetch read issued this cycle
//  f_valid    out  1       pulse: f_data holds the granted fetch's word
//  f_data     out  DATA_W  fetch read data
//  dbg_req    in   1       debug read request, held until dbg_gnt
//  dbg_addr   in   ADDR_W  debug address
//  dbg_gnt    out  1       debug read issued this cycle
//  dbg_valid  out  1       pulse: dbg_data valid
//  dbg_data   out  DATA_W  debug read data
//  mem_en     out  1       BRAM port enable
//  mem_we     out  1       BRAM write enable
//  mem_addr   out  ADDR_W  BRAM address
//  mem_wdata  out  DATA_W  BRAM write data
//  mem_rdata  in   DATA_W  BRAM read data, valid RD_LAT cycles after a read issue
// BEHAVIOUR
//  - Reset values:
//    - FSM=BOOT, all out 0, starve counter 0, tag pipe empty.
//    - In-flight reads at reset are dropped; no valid is emitted for them.
//  - FSM states: BOOT, RUN, DRAIN.
//    - BOOT: only loader is served; f_req/dbg_req ignored (no gnt). ld_req -> mem_en=mem_we=1, ld_ack=1 same cycle.
//    - BOOT->RUN on ld_done. A same-cycle ld_req is still written and acked; RUN starts next cycle.
//    - RUN: core_run=1; loader ignored (ld_ack=0). Per cycle at most one read issue.
//      - Fetch has priority: fetch wins unless the starve counter == STARVE_MAX.
//      - Starve counter increments each cycle dbg_req=1 and dbg_gnt=0. It saturates at STARVE_MAX and clears on dbg_gnt.
//    - RUN->DRAIN on ld_start. core_run drops the same cycle; no new issues.
//    - DRAIN->BOOT when the tag pipe is empty. In-flight reads still deliver f_valid/dbg_valid.
//    - ld_start in BOOT or DRAIN is ignored. ld_start and ld_done together in BOOT: ld_done wins.
//  - Read return:
//    - A 2-bit tag {fetch, debug} is shifted RD_LAT stages alongside each issue.
//    - When it emerges, the matching *_valid pulses for one cycle. *_data = mem_rdata, held until the next valid.
//  - Gnt/ack are combinational from req and state. mem_* are combinational copies of the winning request (zero latency to BRAM).
//  - Write and read never issue in the same cycle. mem_we=0 on every read issue.
//  - Addresses pass unmodified. No wrap or range check: the upper bits are the caller's responsibility.
// STRUCTURE
//  - Shared package core_pkg: state encoding (BOOT=2'd0, RUN=2'd1, DRAIN=2'd2) and requester tag constants TAG_F, TAG_D.
//  - Sub-module rd_tag_pipe:
//    - RD_LAT-deep shift register of tags with an empty flag.
//    - Async reset clears it.
//  - Arbitration, FSM and starve counter stay in the top module.
// TESTING
//  - Boot load: rst then ld_req x4 at addr 0..3, data 0xA0..0xA3.
//    -> 4 ld_ack pulses, mem_we=1 each.
//    -> f_req during boot gives f_gnt=0.
//    -> ld_done gives core_run=1 next cycle.
//  - Fetch latency, RD_LAT=1: f_req addr 2 -> f_gnt same cycle, f_valid next cycle, f_data=0xA2.
//  - Starvation, STARVE_MAX=15: f_req and dbg_req held high.
//    -> fetch granted 15 cycles, then dbg_gnt on cycle 16.
//    -> counter back to 0, fetch regains the port.
//  - Reload: ld_start while 1 fetch is in flight (RD_LAT=3).
//    -> core_run=0 immediately.
//    -> f_valid still arrives 3 cycles after issue.
//    -> BOOT entered the cycle after the pipe empties.
//  - Async reset mid-read: rst asserted between issue and return.
//    -> outputs 0 immediately; no f_valid after rst release.
//    -> FSM=BOOT.
//  - Coincident ld_done + ld_req in BOOT: write acked and performed, RUN next cycle.

Source files
------------

// File: rtl/imem_port_arbiter_pkg.sv
// Shared state encoding and requester tags for the instruction-memory port arbiter.
// Pure definitions: no logic, no latency, no flow control.
package core_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Tag bit 1 marks a fetch read, bit 0 a debug read.
    localparam logic [1:0] TAG_F    = 2'b10;
    localparam logic [1:0] TAG_D    = 2'b01;
    localparam logic [1:0] TAG_NONE = 2'b00;

    function automatic logic [1:0] issue_tag(input logic f_gnt, input logic d_gnt);
        return f_gnt ? TAG_F : (d_gnt ? TAG_D : TAG_NONE);
    endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundle of loader, fetch, debug and BRAM-port signals around the instruction-memory arbiter.
// slave = arbiter side; master = requesters plus the memory macro's read data.
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              ld_start;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ack;
    logic              ld_done;
    logic              core_run;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_valid;
    logic [DATA_W-1:0] f_data;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_valid;
    logic [DATA_W-1:0] dbg_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ld_start, ld_req, ld_addr, ld_data, ld_done,
        input  f_req, f_addr, dbg_req, dbg_addr, mem_rdata,
        output ld_ack, core_run, f_gnt, f_valid, f_data,
        output dbg_gnt, dbg_valid, dbg_data,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ld_start, ld_req, ld_addr, ld_data, ld_done,
        output f_req, f_addr, dbg_req, dbg_addr, mem_rdata,
        input  ld_ack, core_run, f_gnt, f_valid, f_data,
        input  dbg_gnt, dbg_valid, dbg_data,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_port_arbiter_rd_tag_pipe.sv
// RD_LAT-deep shift register carrying the requester tag of each read issue to its data return.
// Latency RD_LAT cycles; never stalls, one tag in and one out every cycle.
module rd_tag_pipe
    import core_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] tag_in,
    output logic [1:0] tag_out,
    output logic       empty
);

    logic [1:0] stg_q [RD_LAT];
    logic [1:0] stg_d [RD_LAT];

    always_comb begin
        stg_d[0] = tag_in;
        for (int i = 1; i < RD_LAT; i++) begin
            stg_d[i] = stg_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stg_q[i] <= TAG_NONE;
            end
        end else begin
            stg_q <= stg_d;
        end
    end

    // Empty only when no stage holds a tag, including the one returning this cycle.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < RD_LAT; i++) begin
            if (stg_q[i] != TAG_NONE) begin
                empty = 1'b0;
            end
        end
    end

    assign tag_out = stg_q[RD_LAT-1];

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-BRAM port between loader writes (boot) and fetch/debug reads (run).
// Grants are combinational, zero-latency to BRAM; read data returns RD_LAT cycles later, requesters hold until granted.
module imem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    imem_port_arbiter_if.slave  bus
);

    localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [DATA_W-1:0] f_hold_q, f_hold_d;
    logic [DATA_W-1:0] d_hold_q, d_hold_d;

    logic              ack_c, f_gnt_c, d_gnt_c, run_c;
    logic [ADDR_W-1:0] addr_c;
    logic [1:0]        tag_in, tag_out;
    logic              pipe_empty;
    logic              f_vld_c, d_vld_c;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        ack_c    = 1'b0;
        f_gnt_c  = 1'b0;
        d_gnt_c  = 1'b0;
        run_c    = 1'b0;
        addr_c   = '0;
        // Holding everything quiet while rst is high keeps the outputs at zero during reset.
        if (!rst) begin
            unique case (state_q)
                ST_BOOT: begin
                    ack_c = bus.ld_req;
                    if (bus.ld_req) addr_c = bus.ld_addr;
                    if (bus.ld_done) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.ld_start) begin
                        state_d = ST_DRAIN;
                    end else begin
                        run_c   = 1'b1;
                        d_gnt_c = bus.dbg_req && ((starve_q == STARVE_LIM) || !bus.f_req);
                        f_gnt_c = bus.f_req && !d_gnt_c;
                    end
                    if (d_gnt_c) begin
                        starve_d = '0;
                    end else if (bus.dbg_req && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + 1'b1;
                    end
                    if (f_gnt_c)      addr_c = bus.f_addr;
                    else if (d_gnt_c) addr_c = bus.dbg_addr;
                end
                ST_DRAIN: begin
                    if (pipe_empty) state_d = ST_BOOT;
                end
                default: state_d = ST_BOOT;
            endcase
        end
        f_vld_c  = |(tag_out & TAG_F);
        d_vld_c  = |(tag_out & TAG_D);
        f_hold_d = f_vld_c ? bus.mem_rdata : f_hold_q;
        d_hold_d = d_vld_c ? bus.mem_rdata : d_hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            starve_q <= '0;
            f_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            f_hold_q <= f_hold_d;
            d_hold_q <= d_hold_d;
        end
    end

    assign tag_in = issue_tag(f_gnt_c, d_gnt_c);

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .empty   (pipe_empty)
    );

    assign bus.ld_ack    = ack_c;
    assign bus.core_run  = run_c;
    assign bus.f_gnt     = f_gnt_c;
    assign bus.dbg_gnt   = d_gnt_c;
    assign bus.mem_en    = ack_c | f_gnt_c | d_gnt_c;
    assign bus.mem_we    = ack_c;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = ack_c ? bus.ld_data : '0;
    assign bus.f_valid   = f_vld_c;
    assign bus.f_data    = f_vld_c ? bus.mem_rdata : f_hold_q;
    assign bus.dbg_valid = d_vld_c;
    assign bus.dbg_data  = d_vld_c ? bus.mem_rdata : d_hold_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Two arbiters (RD_LAT 1 and 3) driven by identical stimulus, each with its own BRAM model,
// checked every cycle against a cycle-stamped reference model plus directed scenario checks.
module tb_imem_port_arbiter;

    localparam int SMAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start, ld_req, ld_done, f_req, dbg_req;
    logic [15:0] ld_addr, f_addr, dbg_addr;
    logic [31:0] ld_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b0 ();
    imem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b1 ();

    assign b0.ld_start = ld_start;  assign b1.ld_start = ld_start;
    assign b0.ld_req   = ld_req;    assign b1.ld_req   = ld_req;
    assign b0.ld_addr  = ld_addr;   assign b1.ld_addr  = ld_addr;
    assign b0.ld_data  = ld_data;   assign b1.ld_data  = ld_data;
    assign b0.ld_done  = ld_done;   assign b1.ld_done  = ld_done;
    assign b0.f_req    = f_req;     assign b1.f_req    = f_req;
    assign b0.f_addr   = f_addr;    assign b1.f_addr   = f_addr;
    assign b0.dbg_req  = dbg_req;   assign b1.dbg_req  = dbg_req;
    assign b0.dbg_addr = dbg_addr;  assign b1.dbg_addr = dbg_addr;

    imem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(SMAX)) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave));
    imem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3), .STARVE_MAX(SMAX)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave));

    // BRAM macros: latency 1 and latency 3
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] r0;
    logic [31:0] p1 [3];

    always @(posedge clk) begin
        if (b0.mem_en) begin
            if (b0.mem_we) mem0[b0.mem_addr[7:0]] <= b0.mem_wdata;
            else           r0 <= mem0[b0.mem_addr[7:0]];
        end
    end
    assign b0.mem_rdata = r0;

    always @(posedge clk) begin
        p1[0] <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr[7:0]] : 32'h0;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
        if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[7:0]] <= b1.mem_wdata;
    end
    assign b1.mem_rdata = p1[2];

    typedef struct packed {
        logic        core_run;
        logic        ld_ack;
        logic        f_gnt;
        logic        dbg_gnt;
        logic        mem_en;
        logic        mem_we;
        logic        f_valid;
        logic        dbg_valid;
        logic [15:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] f_data;
        logic [31:0] dbg_data;
    } obs_t;

    obs_t obs [2];
    obs_t ex  [2];
    assign obs[0] = {b0.core_run, b0.ld_ack, b0.f_gnt, b0.dbg_gnt, b0.mem_en, b0.mem_we,
                     b0.f_valid, b0.dbg_valid, b0.mem_addr, b0.mem_wdata, b0.f_data, b0.dbg_data};
    assign obs[1] = {b1.core_run, b1.ld_ack, b1.f_gnt, b1.dbg_gnt, b1.mem_en, b1.mem_we,
                     b1.f_valid, b1.dbg_valid, b1.mem_addr, b1.mem_wdata, b1.f_data, b1.dbg_data};

    // Reference model: mode 0=boot 1=run 2=drain; reads kept as slots stamped with their return cycle.
    int          m_cyc;
    int          m_mode   [2];
    int          m_starve [2];
    logic [31:0] m_fhold  [2];
    logic [31:0] m_dhold  [2];
    bit          pv   [2][8];
    int          pdue [2][8];
    bit          pf   [2][8];
    logic [31:0] pdat [2][8];
    logic [31:0] mm   [2][256];
    bit          e_fw [2], e_dw [2], e_wr [2], e_empty [2];
    int          e_ret [2];

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) else begin
            n_errors++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, o, e);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_starve[d] = 0; m_fhold[d] = 0; m_dhold[d] = 0;
            for (int k = 0; k < 8; k++) pv[d][k] = 0;
        end
    endtask

    task automatic model_eval(input int d);
        obs_t e;
        e = '0;
        e_fw[d] = 0; e_dw[d] = 0; e_wr[d] = 0; e_ret[d] = -1; e_empty[d] = 1;
        for (int k = 0; k < 8; k++) begin
            if (pv[d][k]) begin
                if (pdue[d][k] == m_cyc) e_ret[d] = k;
                if (pdue[d][k] >= m_cyc) e_empty[d] = 0;
            end
        end
        if (!rst) begin
            if (m_mode[d] == 0) begin
                e_wr[d] = ld_req;
            end else if (m_mode[d] == 1 && !ld_start) begin
                e.core_run = 1;
                e_dw[d] = dbg_req && (m_starve[d] == SMAX || !f_req);
                e_fw[d] = f_req && !e_dw[d];
            end
            e.ld_ack    = e_wr[d];
            e.f_gnt     = e_fw[d];
            e.dbg_gnt   = e_dw[d];
            e.mem_en    = e_wr[d] | e_fw[d] | e_dw[d];
            e.mem_we    = e_wr[d];
            e.mem_addr  = e_wr[d] ? ld_addr : (e_fw[d] ? f_addr : (e_dw[d] ? dbg_addr : 16'h0));
            e.mem_wdata = e_wr[d] ? ld_data : 32'h0;
        end
        e.f_data   = m_fhold[d];
        e.dbg_data = m_dhold[d];
        if (e_ret[d] >= 0) begin
            if (pf[d][e_ret[d]]) begin e.f_valid = 1;   e.f_data   = pdat[d][e_ret[d]]; end
            else                 begin e.dbg_valid = 1; e.dbg_data = pdat[d][e_ret[d]]; end
        end
        ex[d] = e;
    endtask

    task automatic check_dut(input int d);
        chk("core_run",  d, obs[d].core_run,  ex[d].core_run);
        chk("ld_ack",    d, obs[d].ld_ack,    ex[d].ld_ack);
        chk("f_gnt",     d, obs[d].f_gnt,     ex[d].f_gnt);
        chk("dbg_gnt",   d, obs[d].dbg_gnt,   ex[d].dbg_gnt);
        chk("mem_en",    d, obs[d].mem_en,    ex[d].mem_en);
        chk("mem_we",    d, obs[d].mem_we,    ex[d].mem_we);
        chk("f_valid",   d, obs[d].f_valid,   ex[d].f_valid);
        chk("dbg_valid", d, obs[d].dbg_valid, ex[d].dbg_valid);
        chk("f_data",    d, obs[d].f_data,    ex[d].f_data);
        chk("dbg_data",  d, obs[d].dbg_data,  ex[d].dbg_data);
        if (ex[d].mem_en) chk("mem_addr",  d, 32'(obs[d].mem_addr), 32'(ex[d].mem_addr));
        if (ex[d].mem_we) chk("mem_wdata", d, obs[d].mem_wdata, ex[d].mem_wdata);
    endtask

    task automatic model_step(input int d);
        int r;
        int slot;
        if (rst) return;
        r = e_ret[d];
        if (r >= 0) begin
            if (pf[d][r]) m_fhold[d] = pdat[d][r];
            else          m_dhold[d] = pdat[d][r];
            pv[d][r] = 0;
        end
        if (e_wr[d]) mm[d][ld_addr[7:0]] = ld_data;
        if (e_fw[d] || e_dw[d]) begin
            slot = 0;
            while (pv[d][slot]) slot++;
            pv[d][slot]   = 1;
            pdue[d][slot] = m_cyc + lat(d);
            pf[d][slot]   = e_fw[d];
            pdat[d][slot] = e_fw[d] ? mm[d][f_addr[7:0]] : mm[d][dbg_addr[7:0]];
        end
        case (m_mode[d])
            0: if (ld_done) m_mode[d] = 1;
            1: begin
                if (e_dw[d])                             m_starve[d] = 0;
                else if (dbg_req && m_starve[d] < SMAX)  m_starve[d]++;
                if (ld_start) m_mode[d] = 2;
            end
            default: if (e_empty[d]) m_mode[d] = 0;
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            model_eval(d);
            check_dut(d);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_step(d);
        m_cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        ld_start = 0; ld_req = 0; ld_done = 0; f_req = 0; dbg_req = 0;
        ld_addr = 0; ld_data = 0; f_addr = 0; dbg_addr = 0;
    endtask

    task automatic boot_write(input logic [15:0] a, input logic [31:0] dat, input logic done);
        ld_req = 1; ld_addr = a; ld_data = dat; ld_done = done;
        #1;
        chk("boot_ack", 0, b0.ld_ack, 1);
        chk("boot_we",  1, b1.mem_we, 1);
        cycle();
        ld_req = 0; ld_done = 0;
    endtask

    task automatic rand_inputs(input bit allow_mode);
        f_req    = 1'($urandom_range(0, 1));
        f_addr   = 16'($urandom_range(0, 15));
        dbg_req  = 1'($urandom_range(0, 1));
        dbg_addr = 16'($urandom_range(0, 15));
        ld_req   = 1'($urandom_range(0, 1));
        ld_addr  = 16'($urandom_range(0, 15));
        ld_data  = $urandom;
        ld_start = allow_mode && ($urandom_range(0, 19) == 0);
        ld_done  = allow_mode && ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        m_cyc = 0;
        rst = 1;
        idle_inputs();
        model_reset();
        cycle();
        cycle();
        rst = 0;

        // Boot load with fetch/debug requests that must be ignored
        for (int i = 0; i < 16; i++) begin
            f_req = 1; f_addr = 16'(i); dbg_req = 1'($urandom_range(0, 1));
            ld_req = 1; ld_addr = 16'(i); ld_data = (i < 4) ? 32'hA0 + 32'(i) : $urandom;
            #1;
            chk("boot_fgnt", 0, b0.f_gnt, 0);
            chk("boot_ack",  0, b0.ld_ack, 1);
            chk("boot_we",   0, b0.mem_we, 1);
            cycle();
        end
        idle_inputs();

        // Coincident ld_done + ld_req (+ ignored ld_start): write lands, RUN next cycle
        ld_start = 1;
        boot_write(16'd15, 32'hF00D_000F, 1'b1);
        ld_start = 0;
        #1;
        chk("run_after_done", 0, b0.core_run, 1);
        chk("run_after_done", 1, b1.core_run, 1);

        // Fetch latency on the RD_LAT=1 arbiter
        f_req = 1; f_addr = 16'd2;
        #1;
        chk("fetch_gnt", 0, b0.f_gnt, 1);
        cycle();
        f_req = 0;
        #1;
        chk("fetch_valid", 0, b0.f_valid, 1);
        chk("fetch_data",  0, b0.f_data, 32'hA2);
        repeat (3) cycle();

        // Starvation: both held, debug wins on the 16th cycle only
        for (int k = 0; k < 20; k++) begin
            f_req = 1; f_addr = 16'($urandom_range(0, 15));
            dbg_req = 1; dbg_addr = 16'($urandom_range(0, 15));
            #1;
            chk("starve_dgnt", 0, b0.dbg_gnt, (k == 15) ? 32'd1 : 32'd0);
            chk("starve_fgnt", 1, b1.f_gnt,   (k == 15) ? 32'd0 : 32'd1);
            cycle();
        end
        idle_inputs();

        // Randomised run-mode traffic
        for (int k = 0; k < 300; k++) begin
            rand_inputs(1'b0);
            cycle();
        end
        idle_inputs();
        repeat (4) cycle();

        // Reload with one fetch in flight on the RD_LAT=3 arbiter
        f_req = 1; f_addr = 16'd5;
        cycle();
        f_req = 0; ld_start = 1;
        #1;
        chk("reload_run", 1, b1.core_run, 0);
        chk("reload_run", 0, b0.core_run, 0);
        cycle();
        ld_start = 0;
        cycle();
        #1;
        chk("drain_valid", 1, b1.f_valid, 1);
        cycle();
        ld_req = 1; ld_addr = 16'd5; ld_data = 32'h0000_5555;
        #1;
        chk("drain_no_ack", 1, b1.ld_ack, 0);
        cycle();
        #1;
        chk("boot_again_ack", 1, b1.ld_ack, 1);
        cycle();
        idle_inputs();
        for (int i = 0; i < 16; i++) boot_write(16'(i), $urandom, (i == 15) ? 1'b1 : 1'b0);

        // Async reset between issue and return
        f_req = 1; f_addr = 16'd7;
        cycle();
        f_req = 0;
        #2;
        rst = 1;
        model_reset();
        #1;
        chk("rst_run",    1, b1.core_run, 0);
        chk("rst_fvalid", 1, b1.f_valid, 0);
        for (int d = 0; d < 2; d++) begin
            model_eval(d);
            check_dut(d);
        end
        repeat (2) cycle();
        rst = 0;
        repeat (5) cycle();
        f_req = 1;
        #1;
        chk("post_rst_fgnt", 1, b1.f_gnt, 0);
        f_req = 0; ld_req = 1; ld_addr = 16'd3; ld_data = 32'hA3;
        #1;
        chk("post_rst_ack", 1, b1.ld_ack, 1);
        cycle();
        idle_inputs();

        // Fully random, including mode changes
        for (int k = 0; k < 600; k++) begin
            rand_inputs(1'b1);
            cycle();
        end
        idle_inputs();
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
